sigma_act: RTL and testbench
============================

// Module: sigma_act
// PURPOSE
//  Activation stage directly downstream of the MAC. Captures each 16-bit MAC result on the MAC's done pulse.
//  Applies a 2-stage pipelined PLAN sigmoid (shift/add only). Stores results in an activation buffer.
//  The buffer holds one result per neuron and feeds the next layer's MAC inputs (in*_2).
// PARAMETERS
//  DATA_W      16   sample width, signed two's complement, Q3.12 (1.0 = 4096)
//  NUM_NEURONS 10   activation buffer depth (one entry per neuron of the layer)
//  ADDR_W      4    read address width, >= clog2(NUM_NEURONS)
// PORTS
//  clk        in   1       system clock
//  reset      in   1       synchronous, active-high
//  mac_done   in   1       one-cycle valid pulse: mac_out holds a finished sum
//  mac_out    in   DATA_W  MAC result, Q3.12 signed
//  clear      in   1       restart the layer: write pointer and flags return to zero
//  rd_addr    in   ADDR_W  buffer read address
//  rd_data    out  DATA_W  registered buffer read data (latency 1)
//  buf_full   out  1       NUM_NEURONS entries written since the last clear/reset
//  layer_done out  1       one-cycle pulse when the last entry is written
//  overflow   out  1       sticky: a result arrived while buf_full was set
//  busy       out  1       pipeline holds an in-flight sample
// BEHAVIOUR
//  Reset: all outputs 0, buffer contents 0, write pointer 0, pipeline valids 0.
//  S1 (cycle after mac_done): register sign, |x| and valid.
//   |-32768| saturates to 32767.
//  S2: compute y from |x|, then register it. For negative x, y = 4096 - y.
//   |x| >= 20480 (5.0)          -> y = 4096
//   9728 <= |x| < 20480         -> y = (|x|>>5) + 3456
//   4096 <= |x| < 9728          -> y = (|x|>>3) + 2560
//   |x| < 4096                  -> y = (|x|>>2) + 2048
//   Result is always in [0,4096]. Shifts truncate toward zero on the unsigned |x|.
//  Latency: a buffer write occurs 2 cycles after mac_done; throughput is 1 sample/cycle.
//  Buffer write: entry[wr_ptr] <= y, then wr_ptr++.
//   When wr_ptr reaches NUM_NEURONS: buf_full=1 and layer_done pulses in the same cycle.
//   wr_ptr never wraps.
//  Write while buf_full=1: sample dropped, buffer unchanged, overflow set.
//   overflow clears only on clear or reset.
//  clear + S2 write in the same cycle: clear wins for the flags.
//   The incoming sample is written to entry 0 and wr_ptr becomes 1.
//   Samples still in S1 are kept and land after the clear.
//  Buffer contents are not erased by clear; only the pointer and flags reset.
//  rd_addr >= NUM_NEURONS: rd_data = 0. A read-during-write to the same entry returns the old value.
//  busy = S1 valid OR S2 valid.
//  Reset asserted mid-operation drops all in-flight samples.
// CONFIGURATION
//  SIGMA_RELU_EN defined: adds input port act_sel (1 bit), sampled with mac_done and pipelined with the data.
//   act_sel=1 selects ReLU: y = x<0 ? 0 : x, with no saturation.
//   act_sel=0 selects the sigmoid.
//  SIGMA_RELU_EN undefined: the act_sel port does not exist and the block is sigmoid-only.
// STRUCTURE
//  Package sigma_pkg holds:
//   Q_FRAC=12, ONE_Q=4096
//   breakpoints BP_5_0=20480, BP_2_375=9728, BP_1_0=4096
//   offsets OFF_A=3456, OFF_B=2560, OFF_C=2048
//   typedef act_t (signed [DATA_W-1:0])
//  Sub-module sigma_plan: the 2-stage PLAN pipeline (data, valid in/out, optional act_sel).
//  sigma_act wraps sigma_plan with the buffer, pointer and flags.
// TESTING
//  x=0 pulse -> entry0=2048 two cycles later. x=4096 -> 3072. x=-4096 -> 1024.
//  x=16384 -> 3968; x=30000 -> 4096; x=-32768 -> 0 (saturation path).
//  Ten back-to-back pulses -> entries 0..9 filled in order; layer_done pulses exactly once.
//   buf_full=1 on the 10th write.
//  11th pulse with buf_full=1 -> overflow=1, entry 9 unchanged.
//   Then clear -> buf_full=0 and overflow=0.
//  clear in the same cycle as an S2 write of x=0 -> entry0=2048, wr_ptr=1, layer_done=0.
//  Reset mid-burst (3 samples in flight) -> no writes; all outputs 0 on the next cycle.
//   With SIGMA_RELU_EN: act_sel=1, x=-100 -> 0; x=5000 -> 5000.

Source files
------------

// File: rtl/sigma_pkg.sv
// Shared constants and types for the sigma_act activation stage.
// Fixed-point format is Q3.12 signed: 1.0 == ONE_Q.
// Optional feature macro used by this slice: SIGMA_RELU_EN.
package sigma_pkg;

    localparam int unsigned ACT_W    = 16;
    localparam int unsigned Q_FRAC   = 12;
    localparam int unsigned ONE_Q    = 1 << Q_FRAC;   // 4096

    // PLAN breakpoints on |x|
    localparam int unsigned BP_5_0   = 20480;
    localparam int unsigned BP_2_375 = 9728;
    localparam int unsigned BP_1_0   = 4096;

    // PLAN segment offsets
    localparam int unsigned OFF_A    = 3456;
    localparam int unsigned OFF_B    = 2560;
    localparam int unsigned OFF_C    = 2048;

    typedef logic signed [ACT_W-1:0] act_t;

    typedef enum logic {
        ACT_SIGMOID = 1'b0,
        ACT_RELU    = 1'b1
    } act_mode_e;

endpackage

// File: rtl/sigma_plan.sv
// Two-stage PLAN sigmoid pipeline.
// S1 registers sign and saturated magnitude; S2 evaluates the piecewise
// curve and mirrors it for negative inputs.
// With SIGMA_RELU_EN defined, a per-sample act_sel bit travels with the
// data and selects ReLU instead of the sigmoid.
module sigma_plan
    import sigma_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
`ifdef SIGMA_RELU_EN
    input  logic              in_act_sel,
`endif
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              s1_valid,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    localparam logic [DATA_W-1:0] MAG_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic              s1_valid_q, s1_valid_d;
    logic              s1_sign_q,  s1_sign_d;
    logic [DATA_W-1:0] s1_mag_q,   s1_mag_d;
`ifdef SIGMA_RELU_EN
    act_mode_e         s1_mode_q,  s1_mode_d;
`endif
    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s2_y_q,     s2_y_d;
    logic [DATA_W-1:0] curve_y;

    // S1: split the sample into sign and magnitude, saturating the most negative code
    always_comb begin
        s1_valid_d = in_valid;
        s1_sign_d  = in_data[DATA_W-1];
        if (!in_data[DATA_W-1]) begin
            s1_mag_d = in_data;
        end else if (in_data == MOST_NEG) begin
            s1_mag_d = MAG_MAX;
        end else begin
            s1_mag_d = -in_data;
        end
`ifdef SIGMA_RELU_EN
        s1_mode_d = in_act_sel ? ACT_RELU : ACT_SIGMOID;
`endif
    end

    // S2: evaluate the PLAN segment on |x|, then mirror about 0.5 for negative x
    always_comb begin
        s2_valid_d = s1_valid_q;
        if (s1_mag_q >= DATA_W'(BP_5_0)) begin
            curve_y = DATA_W'(ONE_Q);
        end else if (s1_mag_q >= DATA_W'(BP_2_375)) begin
            curve_y = (s1_mag_q >> 5) + DATA_W'(OFF_A);
        end else if (s1_mag_q >= DATA_W'(BP_1_0)) begin
            curve_y = (s1_mag_q >> 3) + DATA_W'(OFF_B);
        end else begin
            curve_y = (s1_mag_q >> 2) + DATA_W'(OFF_C);
        end
        s2_y_d = s1_sign_q ? (DATA_W'(ONE_Q) - curve_y) : curve_y;
`ifdef SIGMA_RELU_EN
        if (s1_mode_q == ACT_RELU) begin
            s2_y_d = s1_sign_q ? '0 : s1_mag_q;
        end
`endif
    end

    // Pipeline registers; reset flushes every in-flight sample
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_mag_q   <= '0;
`ifdef SIGMA_RELU_EN
            s1_mode_q  <= ACT_SIGMOID;
`endif
            s2_valid_q <= 1'b0;
            s2_y_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_mag_q   <= s1_mag_d;
`ifdef SIGMA_RELU_EN
            s1_mode_q  <= s1_mode_d;
`endif
            s2_valid_q <= s2_valid_d;
            s2_y_q     <= s2_y_d;
        end
    end

    assign s1_valid  = s1_valid_q;
    assign out_valid = s2_valid_q;
    assign out_data  = s2_y_q;

endmodule

// File: rtl/sigma_act.sv
// Activation stage after the MAC: PLAN sigmoid pipeline feeding a
// per-neuron activation buffer with fill/overflow flags.
// Optional macro SIGMA_RELU_EN adds the act_sel port (ReLU select).
module sigma_act
    import sigma_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned NUM_NEURONS = 10,
    parameter int unsigned ADDR_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
`ifdef SIGMA_RELU_EN
    input  logic              act_sel,
`endif
    input  logic              mac_done,
    input  logic [DATA_W-1:0] mac_out,
    input  logic              clear,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              buf_full,
    output logic              layer_done,
    output logic              overflow,
    output logic              busy
);

    localparam int unsigned PTR_W = $clog2(NUM_NEURONS + 1);

    logic              s1_valid;
    logic              s2_valid;
    logic [DATA_W-1:0] s2_y;

    logic [DATA_W-1:0] mem_q [NUM_NEURONS];
    logic [DATA_W-1:0] mem_d [NUM_NEURONS];
    logic [PTR_W-1:0]  wr_ptr_q,     wr_ptr_d;
    logic              buf_full_q,   buf_full_d;
    logic              layer_done_q, layer_done_d;
    logic              overflow_q,   overflow_d;
    logic [DATA_W-1:0] rd_data_q,    rd_data_d;

    sigma_plan #(
        .DATA_W (DATA_W)
    ) u_plan (
        .clk        (clk),
        .reset      (reset),
`ifdef SIGMA_RELU_EN
        .in_act_sel (act_sel),
`endif
        .in_valid   (mac_done),
        .in_data    (mac_out),
        .s1_valid   (s1_valid),
        .out_valid  (s2_valid),
        .out_data   (s2_y)
    );

    // Buffer write, pointer and flags; clear overrides the flags but a
    // colliding S2 result still lands in entry 0
    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        buf_full_d   = buf_full_q;
        overflow_d   = overflow_q;
        layer_done_d = 1'b0;
        if (clear) begin
            wr_ptr_d   = '0;
            buf_full_d = 1'b0;
            overflow_d = 1'b0;
            if (s2_valid) begin
                mem_d[0] = s2_y;
                wr_ptr_d = PTR_W'(1);
            end
        end else if (s2_valid) begin
            if (buf_full_q) begin
                overflow_d = 1'b1;
            end else begin
                for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
                    if (PTR_W'(i) == wr_ptr_q) begin
                        mem_d[i] = s2_y;
                    end
                end
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                if (wr_ptr_q == PTR_W'(NUM_NEURONS - 1)) begin
                    buf_full_d   = 1'b1;
                    layer_done_d = 1'b1;
                end
            end
        end
    end

    // Read port samples the pre-write contents; out-of-range addresses read 0
    always_comb begin
        rd_data_d = '0;
        for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
            if (ADDR_W'(i) == rd_addr) begin
                rd_data_d = mem_q[i];
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            buf_full_q   <= 1'b0;
            layer_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            buf_full_q   <= buf_full_d;
            layer_done_q <= layer_done_d;
            overflow_q   <= overflow_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign buf_full   = buf_full_q;
    assign layer_done = layer_done_q;
    assign overflow   = overflow_q;
    assign busy       = s1_valid | s2_valid;

endmodule

// File: tb/tb_sigma_act.sv
// Directed bench for sigma_act: PLAN values, buffer fill, overflow,
// clear collisions, read behaviour and mid-burst reset.
// SIGMA_RELU_EN adds the ReLU scenario.
module tb_sigma_act;

    logic        clk = 1'b0;
    logic        reset;
    logic        mac_done;
    logic [15:0] mac_out;
    logic        clear;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic        buf_full;
    logic        layer_done;
    logic        overflow;
    logic        busy;
`ifdef SIGMA_RELU_EN
    logic        act_sel;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sigma_act #(
        .DATA_W      (16),
        .NUM_NEURONS (10),
        .ADDR_W      (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef SIGMA_RELU_EN
        .act_sel    (act_sel),
`endif
        .mac_done   (mac_done),
        .mac_out    (mac_out),
        .clear      (clear),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .buf_full   (buf_full),
        .layer_done (layer_done),
        .overflow   (overflow),
        .busy       (busy)
    );

    task automatic read_entry(input logic [3:0] a, output logic [15:0] d);
        @(negedge clk) rd_addr = a;
        @(negedge clk) d = rd_data;
    endtask

    task automatic pulse(input logic [15:0] x);
        @(negedge clk) begin mac_done = 1'b1; mac_out = x; end
        @(negedge clk) mac_done = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL %s_idle: busy=%b want 0", tag, busy); end
    endtask

    task automatic test_reset;
        reset = 1'b1; mac_done = 1'b0; mac_out = '0; clear = 1'b0; rd_addr = '0;
`ifdef SIGMA_RELU_EN
        act_sel = 1'b0;
`endif
        repeat (3) @(negedge clk);
        total++; if (rd_data !== 16'd0)  begin bad++; $display("FAIL reset_rd_data: got %0d want 0", rd_data); end
        total++; if (buf_full !== 1'b0)  begin bad++; $display("FAIL reset_buf_full: got %b want 0", buf_full); end
        total++; if (layer_done !== 1'b0) begin bad++; $display("FAIL reset_layer_done: got %b want 0", layer_done); end
        total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset = 1'b0;
    endtask

    // Ten consecutive samples covering every PLAN segment and breakpoint
    task automatic test_back_to_back;
        logic [15:0] xs [10];
        logic [15:0] ys [10];
        logic [15:0] d;
        int ld_cnt, ld_cycle;
        xs = '{16'h0000,   // 0
               16'h1000,   // 4096
               16'hF000,   // -4096
               16'h4000,   // 16384
               16'h7530,   // 30000
               16'h8000,   // -32768
               16'h25FF,   // 9727
               16'h2600,   // 9728
               16'h4FFF,   // 20479
               16'hFFFF};  // -1
        ys = '{16'd2048, 16'd3072, 16'd1024, 16'd3968, 16'd4096,
               16'd0,    16'd3775, 16'd3760, 16'd4095, 16'd2048};
        ld_cnt = 0; ld_cycle = -1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c == 1) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy: got %b want 1", busy); end
            end
            if (c == 11) begin
                total++; if (buf_full !== 1'b0) begin bad++; $display("FAIL b2b_full_early: got %b want 0", buf_full); end
            end
            if (layer_done === 1'b1) begin
                ld_cnt++; ld_cycle = c;
                total++; if (buf_full !== 1'b1) begin bad++; $display("FAIL b2b_full_with_done: got %b want 1", buf_full); end
            end
            if (c < 10) begin mac_done = 1'b1; mac_out = xs[c]; end
            else mac_done = 1'b0;
        end
        total++; if (ld_cnt != 1)    begin bad++; $display("FAIL b2b_done_count: got %0d want 1", ld_cnt); end
        total++; if (ld_cycle != 12) begin bad++; $display("FAIL b2b_done_cycle: got %0d want 12", ld_cycle); end
        total++; if (buf_full !== 1'b1) begin bad++; $display("FAIL b2b_full: got %b want 1", buf_full); end
        for (int i = 0; i < 10; i++) begin
            read_entry(4'(i), d);
            total++; if (d !== ys[i]) begin bad++; $display("FAIL b2b_entry%0d: got %0d want %0d", i, d, ys[i]); end
        end
    endtask

    task automatic test_overflow;
        logic [15:0] d;
        pulse(16'h7530);
        wait_idle("ovf");
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
        total++; if (buf_full !== 1'b1) begin bad++; $display("FAIL ovf_full: got %b want 1", buf_full); end
        read_entry(4'd9, d);
        total++; if (d !== 16'd2048) begin bad++; $display("FAIL ovf_entry9: got %0d want 2048", d); end
        @(negedge clk) clear = 1'b1;
        @(negedge clk);
        total++; if (buf_full !== 1'b0) begin bad++; $display("FAIL clr_full: got %b want 0", buf_full); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clr_overflow: got %b want 0", overflow); end
        clear = 1'b0;
    endtask

    // clear coincides with the S2 write of x=0 while x=-4096 sits in S1
    task automatic test_clear_collide;
        logic [15:0] d;
        int ld_cnt;
        pulse(16'h1000);
        wait_idle("pre_collide");
        ld_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (layer_done === 1'b1) ld_cnt++;
            case (c)
                0: begin mac_done = 1'b1; mac_out = 16'h0000; end
                1: begin mac_done = 1'b1; mac_out = 16'hF000; end
                2: begin mac_done = 1'b0; clear = 1'b1; end
                3: clear = 1'b0;
                default: ;
            endcase
        end
        total++; if (ld_cnt != 0) begin bad++; $display("FAIL collide_done: got %0d pulses want 0", ld_cnt); end
        total++; if (buf_full !== 1'b0) begin bad++; $display("FAIL collide_full: got %b want 0", buf_full); end
        read_entry(4'd0, d);
        total++; if (d !== 16'd2048) begin bad++; $display("FAIL collide_entry0: got %0d want 2048", d); end
        read_entry(4'd1, d);
        total++; if (d !== 16'd1024) begin bad++; $display("FAIL collide_entry1: got %0d want 1024", d); end
    endtask

    // Entry 2 still holds 1024; the next write (ptr=2) stores 3968 there
    task automatic test_read_during_write;
        @(negedge clk) begin rd_addr = 4'd2; mac_done = 1'b1; mac_out = 16'h4000; end
        @(negedge clk) mac_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (rd_data !== 16'd1024) begin bad++; $display("FAIL rdw_old: got %0d want 1024", rd_data); end
        @(negedge clk);
        total++; if (rd_data !== 16'd3968) begin bad++; $display("FAIL rdw_new: got %0d want 3968", rd_data); end
    endtask

    task automatic test_read_oob;
        logic [15:0] d;
        read_entry(4'd10, d);
        total++; if (d !== 16'd0) begin bad++; $display("FAIL oob_10: got %0d want 0", d); end
        read_entry(4'd15, d);
        total++; if (d !== 16'd0) begin bad++; $display("FAIL oob_15: got %0d want 0", d); end
    endtask

    task automatic test_reset_midburst;
        logic [15:0] d;
        @(negedge clk) begin rd_addr = 4'd2; mac_done = 1'b1; mac_out = 16'h1000; end
        @(negedge clk) mac_out = 16'hF000;
        @(negedge clk) begin mac_out = 16'h0000; reset = 1'b1; end
        @(negedge clk);
        total++; if (rd_data !== 16'd0)   begin bad++; $display("FAIL mid_rd_data: got %0d want 0", rd_data); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
        total++; if (layer_done !== 1'b0) begin bad++; $display("FAIL mid_done: got %b want 0", layer_done); end
        total++; if (buf_full !== 1'b0)   begin bad++; $display("FAIL mid_full: got %b want 0", buf_full); end
        total++; if (overflow !== 1'b0)   begin bad++; $display("FAIL mid_overflow: got %b want 0", overflow); end
        mac_done = 1'b0; reset = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy_after: got %b want 0", busy); end
        read_entry(4'd0, d);
        total++; if (d !== 16'd0) begin bad++; $display("FAIL mid_entry0: got %0d want 0", d); end
        read_entry(4'd1, d);
        total++; if (d !== 16'd0) begin bad++; $display("FAIL mid_entry1: got %0d want 0", d); end
    endtask

`ifdef SIGMA_RELU_EN
    task automatic test_relu;
        logic [15:0] d;
        @(negedge clk) begin act_sel = 1'b1; mac_done = 1'b1; mac_out = 16'hFF9C; end // -100
        @(negedge clk) mac_out = 16'h1388;                                           // 5000
        @(negedge clk) act_sel = 1'b0;                                               // 5000, sigmoid
        @(negedge clk) mac_done = 1'b0;
        wait_idle("relu");
        read_entry(4'd0, d);
        total++; if (d !== 16'd0)    begin bad++; $display("FAIL relu_neg: got %0d want 0", d); end
        read_entry(4'd1, d);
        total++; if (d !== 16'd5000) begin bad++; $display("FAIL relu_pos: got %0d want 5000", d); end
        read_entry(4'd2, d);
        total++; if (d !== 16'd3185) begin bad++; $display("FAIL relu_off_sig: got %0d want 3185", d); end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_overflow();
        test_clear_collide();
        test_read_during_write();
        test_read_oob();
        test_reset_midburst();
`ifdef SIGMA_RELU_EN
        test_relu();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
